// File: rtl/lane_pipe_valid.sv
// Multi-lane elastic pipeline register (LANES x WIDTH + lane enables), DEPTH stages.
// Latency DEPTH-1 cycles after acceptance on an empty pipe; one beat per cycle.
// Backpressure: combinational ready chain from out_ready; LANE_PIPE_VALID_FLUSH_EN adds flush.
module lane_pipe_valid #(
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*WIDTH-1:0]        in_data,
    input  logic [LANES-1:0]              in_lane_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*WIDTH-1:0]        out_data,
    output logic [LANES-1:0]              out_lane_en,
`ifdef LANE_PIPE_VALID_FLUSH_EN
    input  logic                          flush,
`endif
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int DW    = LANES * WIDTH;
    localparam int OCC_W = $clog2(DEPTH+1);

    logic           v_q    [DEPTH];
    logic           v_d    [DEPTH];
    logic [DW-1:0]  data_q [DEPTH];
    logic [DW-1:0]  data_d [DEPTH];
    logic [LANES-1:0] en_q [DEPTH];
    logic [LANES-1:0] en_d [DEPTH];
    logic           ld     [DEPTH];
    logic           unl    [DEPTH];
    logic [DW-1:0]  src_data [DEPTH];
    logic [LANES-1:0] src_en [DEPTH];
    logic [DW-1:0]  in_masked;
    logic           flush_w;

`ifdef LANE_PIPE_VALID_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Disabled lanes are zeroed at capture; the enable mask itself is kept as-is.
    always_comb begin
        in_masked = '0;
        for (int k = 0; k < LANES; k++) begin
            if (in_lane_en[k]) begin
                in_masked[k*WIDTH +: WIDTH] = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Ready ripples from the output stage back to the input within one cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ld[i]  = 1'b0;
            unl[i] = 1'b0;
        end
        unl[DEPTH-1] = v_q[DEPTH-1] && out_ready;
        for (int i = DEPTH-1; i > 0; i--) begin
            ld[i]    = v_q[i-1] && (!v_q[i] || unl[i]);
            unl[i-1] = ld[i];
        end
        in_ready = !reset && !flush_w && (!v_q[0] || unl[0]);
        ld[0]    = in_valid && in_ready;
    end

    always_comb begin
        src_data[0] = in_masked;
        src_en[0]   = in_lane_en;
        for (int i = 1; i < DEPTH; i++) begin
            src_data[i] = data_q[i-1];
            src_en[i]   = en_q[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            v_d[i]    = v_q[i];
            data_d[i] = data_q[i];
            en_d[i]   = en_q[i];
            if (flush_w) begin
                v_d[i]    = 1'b0;
                data_d[i] = '0;
                en_d[i]   = '0;
            end else if (ld[i]) begin
                v_d[i]    = 1'b1;
                data_d[i] = src_data[i];
                en_d[i]   = src_en[i];
            end else if (unl[i]) begin
                v_d[i]    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                v_q[i]    <= 1'b0;
                data_q[i] <= '0;
                en_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                v_q[i]    <= v_d[i];
                data_q[i] <= data_d[i];
                en_q[i]   <= en_d[i];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v_q[i]);
        end
    end

    // Stale data in an emptied last stage stays hidden behind out_valid.
    assign out_valid   = v_q[DEPTH-1];
    assign out_data    = out_valid ? data_q[DEPTH-1] : '0;
    assign out_lane_en = out_valid ? en_q[DEPTH-1]   : '0;

endmodule

// File: tb/tb_lane_pipe_valid.sv
// Scoreboard bench for lane_pipe_valid (LANES=4, WIDTH=8, DEPTH=2); flush phase with LANE_PIPE_VALID_FLUSH_EN.
module tb_lane_pipe_valid;

    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int DW    = LANES * WIDTH;

    logic                clk;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_data;
    logic [LANES-1:0]    in_lane_en;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    logic [LANES-1:0]    out_lane_en;
    logic [1:0]          occupancy;
`ifdef LANE_PIPE_VALID_FLUSH_EN
    logic                flush;
`endif

    lane_pipe_valid #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_lane_en  (in_lane_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_lane_en (out_lane_en),
`ifdef LANE_PIPE_VALID_FLUSH_EN
        .flush       (flush),
`endif
        .occupancy   (occupancy)
    );

    typedef struct {
        logic [DW-1:0]    d;
        logic [LANES-1:0] e;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   lat_chk = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mask_model(input logic [DW-1:0] d, input logic [LANES-1:0] e);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            if (e[k]) r[k*WIDTH +: WIDTH] = d[k*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    // Handshakes are sampled mid-cycle, before the edge that commits them.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            sb.delete();
        end
`ifdef LANE_PIPE_VALID_FLUSH_EN
        else if (flush) begin
            sb.delete();
        end
`endif
        else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_lane_en", out_lane_en, e.e);
                    if (lat_chk) chk("latency", cyc - e.cyc, DEPTH);
                end
            end
            if (in_valid && in_ready) begin
                e.d   = mask_model(in_data, in_lane_en);
                e.e   = in_lane_en;
                e.cyc = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] held;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_lane_en = '0;
        out_ready  = 1'b0;
`ifdef LANE_PIPE_VALID_FLUSH_EN
        flush      = 1'b0;
`endif
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("rdy_after_rst", in_ready, 1);

        // Streaming with fixed latency and no gaps
        step();
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid   = 1'b1;
            in_data    = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            in_lane_en = 4'hf;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("stream_occ", occupancy, 0);
        chk("stream_sb", sb.size(), 0);
        lat_chk = 1'b0;

        // Backpressure from the fifth cycle on
        for (int k = 0; k < 12; k++) begin
            in_valid   = 1'b1;
            in_data    = $urandom;
            in_lane_en = 4'($urandom);
            out_ready  = (k < 5);
            step();
        end
        chk("bp_occ", occupancy, 2);
        chk("bp_in_ready", in_ready, 0);
        held = out_data;
        step();
        chk("bp_hold", out_data, held);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (6) step();
        chk("bp_sb", sb.size(), 0);
        chk("bp_occ_drained", occupancy, 0);

        // Lane masking
        in_valid   = 1'b1;
        in_data    = 32'hAABBCCDD;
        in_lane_en = 4'b0101;
        step();
        in_valid = 1'b0;
        for (int t = 0; t < 20 && !out_valid; t++) step();
        chk("mask_seen", out_valid, 1);
        chk("mask_data", out_data, 32'h00BB00DD);
        chk("mask_en", out_lane_en, 4'b0101);
        repeat (3) step();

        // Full pipe with simultaneous load and unload
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid   = 1'b1;
            in_data    = 32'h11110000 + k;
            in_lane_en = 4'hf;
            step();
        end
        chk("simul_full", occupancy, 2);
        out_ready = 1'b1;
        in_data   = 32'h22222222;
        #1 chk("simul_in_ready", in_ready, 1);
        step();
        chk("simul_occ", occupancy, 2);
        in_valid = 1'b0;
        repeat (4) step();
        chk("simul_sb", sb.size(), 0);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            in_valid   = 1'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            in_data    = $urandom;
            in_lane_en = 4'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        chk("rand_sb", sb.size(), 0);

        // Asynchronous reset with beats held
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h33330000 + k;
            step();
        end
        in_valid = 1'b0;
        chk("arst_pre_occ", occupancy, 2);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_en", out_lane_en, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("arst_rdy", in_ready, 1);
        out_ready = 1'b1;
        step();

`ifdef LANE_PIPE_VALID_FLUSH_EN
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h44440000 + k;
            step();
        end
        chk("flush_pre_occ", occupancy, 2);
        flush    = 1'b1;
        in_data  = 32'h55555555;
        #1 chk("flush_in_ready", in_ready, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", occupancy, 0);
        chk("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (3) step();
        chk("flush_occ_after", occupancy, 0);
`endif

        chk("final_sb", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lane_pipe_valid.md
# lane_pipe_valid

Parametrised multi-lane pipeline register with valid/ready flow control for the PCIe physical-layer datapath. It carries LANES lanes of WIDTH bits, plus a per-lane enable mask, through DEPTH elastic stages. It supports full throughput and backpressure. It replaces fixed 4-lane single-bit flop banks between the byte-striping, scrambling and serialisation stages.

## Interface
- LANES, 4, number of lanes (1..16)
- WIDTH, 8, bits per lane (≥1)
- DEPTH, 2, number of pipeline stages (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts input this cycle
- in_data  in  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]
- in_lane_en  in  LANES  per-lane enable of the input beat
- out_valid  out  1  output stage holds a beat
- out_ready  in  1  downstream accepts the output beat
- out_data  out  LANES*WIDTH  output beat, same lane packing
- out_lane_en  out  LANES  lane enables of the output beat
- occupancy  out  $clog2(DEPTH+1)  number of full stages
- flush  in  1  present only with LANE_PIPE_VALID_FLUSH_EN

## Operation
- Stages 0..DEPTH-1. Each stage has a full flag v[i], a data register, and a lane-enable register. Stage DEPTH-1 drives out_*.
- Unload of the last stage: out_valid && out_ready. Unload of stage i<DEPTH-1: v[i] && stage i+1 loads.
- Stage i loads from its predecessor (stage 0 from the input) when the predecessor is full or in_valid (stage 0), and the stage is empty or unloading this cycle.
- in_ready = !reset && (!v[0] || stage 0 unloads). This is a combinational ready chain from out_ready; no registered skid.
- Input accepted on in_valid && in_ready.
- Capture masking: in a captured beat, lane k data is stored as 0 when in_lane_en[k]=0. in_lane_en is stored unchanged.
- A stage that neither loads nor unloads holds its value. out_data and out_lane_en stay stable while out_valid && !out_ready.
- A stage that unloads without loading clears v. Its data register keeps its last value, which is not observable because out_* is gated to 0 when !out_valid.
- occupancy = popcount(v), range 0..DEPTH.
- Ordering: strict FIFO. No beat is dropped or duplicated except by flush.

## Timing
- Reset asserted, asynchronously: all v=0, all registers 0. out_valid=0, out_data=0, out_lane_en=0, occupancy=0, in_ready=0.
- After reset deasserts: in_ready=1 in the same cycle.
- Reset mid-operation discards all held beats immediately, without waiting for a clock edge.
- Latency on an empty pipe: a beat accepted at edge n is visible on out_* after edge n+DEPTH-1. For example, with DEPTH=2, out_valid rises one cycle after acceptance.
- Throughput: one beat per cycle while out_ready=1.
- Full pipe (occupancy=DEPTH) with out_ready=0: in_ready=0.
- Full pipe with out_ready=1: in_ready=1. Simultaneous load and unload leaves occupancy unchanged.
- Occupancy updates at the same edge as v.
- DEPTH=1: a single stage; in_ready = !v[0] || out_ready.

## Configuration
- LANE_PIPE_VALID_FLUSH_EN defined:
  - Adds the flush input.
  - flush=1 at a rising edge clears all v and all data/lane-enable registers. It overrides any load or unload in that cycle.
  - While flush=1, in_ready=0, so an in_valid beat is not accepted.
  - out_valid falls after that edge. Occupancy reads 0 after the edge.
- Macro undefined: no flush port, and the pipe drains only through out_ready.

## Test plan
- Reset: assert reset mid-stream with 2 beats held → out_valid=0, occupancy=0, out_data=0 immediately. in_ready=1 in the cycle after deassertion.
- Streaming: LANES=4, WIDTH=8, DEPTH=2, out_ready=1, beats 0x03020100, 0x07060504, … every cycle → identical sequence on out_data, one cycle after acceptance, no gaps.
- Backpressure: out_ready=0 from cycle 5 while in_valid=1 → occupancy reaches 2 and in_ready=0. out_data holds its beat. On release, all beats emerge in order with no loss.
- Lane masking: in_data=0xAABBCCDD, in_lane_en=4'b0101 → out_data=0x00BB00DD, out_lane_en=4'b0101.
- Simultaneous: full pipe, out_ready=1 and in_valid=1 on the same edge → occupancy stays 2 and the new beat appears DEPTH beats later.
- Flush (macro defined): 2 beats held, flush=1 with in_valid=1 → next cycle occupancy=0, out_valid=0, and the input beat is not accepted (in_ready=0).
